// File: rtl/auth_pkg.sv
// Shared types, default credential tables and width helpers for the login controller.
package auth_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PW_ENTRY = 3'd1,
    CHECK    = 3'd2,
    GRANTED  = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  localparam logic [15:0] DEF_ID_TABLE = 16'h4321;
  localparam logic [31:0] DEF_PW_TABLE = 32'h0F773CA5;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Register width for a value range; never narrower than one bit.
  function automatic int width_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/auth_cred_lookup.sv
// Combinational credential lookup: lowest-index ID match and stored password fetch.
module auth_cred_lookup
  import auth_pkg::*;
#(
  parameter int NUM_USERS = 4,
  parameter int DIGIT_W   = 4,
  parameter int PW_DIGITS = 2,
  parameter logic [NUM_USERS*DIGIT_W-1:0]           ID_TABLE = DEF_ID_TABLE,
  parameter logic [NUM_USERS*PW_DIGITS*DIGIT_W-1:0] PW_TABLE = DEF_PW_TABLE,
  localparam int IDX_W = width_of(NUM_USERS),
  localparam int PW_W  = PW_DIGITS * DIGIT_W
) (
  input  logic [DIGIT_W-1:0] digit,
  input  logic [IDX_W-1:0]   index,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_idx,
  output logic [PW_W-1:0]    pw
);

  // Scan downward so the lowest matching entry is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_USERS - 1; i >= 0; i--) begin
      if (ID_TABLE[i*DIGIT_W +: DIGIT_W] == digit) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign pw = PW_TABLE[int'(index)*PW_W +: PW_W];

endmodule

// File: rtl/multi_user_auth.sv
// Two-stage login controller: ID, then multi-digit password, with failure lockout.
// state    | meaning
// IDLE     | waiting for an ID digit
// PW_ENTRY | ID accepted, collecting password digits
// CHECK    | one-cycle password compare
// GRANTED  | session active
// LOCKOUT  | too many failures, inputs ignored until timer expires
module multi_user_auth
  import auth_pkg::*;
#(
  parameter int NUM_USERS = 4,
  parameter int DIGIT_W   = 4,
  parameter int PW_DIGITS = 2,
  parameter logic [NUM_USERS*DIGIT_W-1:0]           ID_TABLE = DEF_ID_TABLE,
  parameter logic [NUM_USERS*PW_DIGITS*DIGIT_W-1:0] PW_TABLE = DEF_PW_TABLE,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16,
  localparam int IDX_W  = width_of(NUM_USERS),
  localparam int CNT_W  = width_of(PW_DIGITS + 1),
  localparam int FAIL_W = width_of(MAX_FAIL + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               enter,
  input  logic               logout,
  input  logic               timeout,
  output logic               logged_in,
  output logic               id_ok,
  output logic [IDX_W-1:0]   matched_id,
  output logic [CNT_W-1:0]   digit_cnt,
  output logic [FAIL_W-1:0]  fail_cnt,
  output logic               locked
);

  localparam int PW_W  = PW_DIGITS * DIGIT_W;
  localparam int LCK_W = width_of(LOCK_CYCLES);
  localparam logic [CNT_W-1:0]  PW_LAST   = CNT_W'(PW_DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(PW_DIGITS);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
  localparam logic [LCK_W-1:0]  LOCK_INIT = LCK_W'(LOCK_CYCLES - 1);

  state_t               state, state_n;
  logic [PW_W-1:0]      pw_buf, buf_n;
  logic [LCK_W-1:0]     lock_cnt, lcnt_n;
  logic [CNT_W-1:0]     dcnt_n;
  logic [FAIL_W-1:0]    fcnt_n;
  logic [IDX_W-1:0]     idx_n, hit_idx;
  logic                 id_ok_n, li_n, locked_n, hit, fail_ev;
  logic [PW_W-1:0]      stored_pw;
  logic [PW_W+DIGIT_W-1:0] shifted;

  auth_cred_lookup #(
    .NUM_USERS (NUM_USERS),
    .DIGIT_W   (DIGIT_W),
    .PW_DIGITS (PW_DIGITS),
    .ID_TABLE  (ID_TABLE),
    .PW_TABLE  (PW_TABLE)
  ) u_lookup (
    .digit   (digit_in),
    .index   (matched_id),
    .hit     (hit),
    .hit_idx (hit_idx),
    .pw      (stored_pw)
  );

  assign shifted = {pw_buf, digit_in};

  always_comb begin
    state_n  = state;
    buf_n    = pw_buf;
    dcnt_n   = digit_cnt;
    fcnt_n   = fail_cnt;
    idx_n    = matched_id;
    id_ok_n  = id_ok;
    li_n     = logged_in;
    locked_n = locked;
    lcnt_n   = lock_cnt;
    fail_ev  = 1'b0;
    case (state)
      IDLE: if (!timeout && enter) begin
        if (hit) begin
          idx_n   = hit_idx;
          id_ok_n = 1'b1;
          dcnt_n  = '0;
          buf_n   = '0;
          state_n = PW_ENTRY;
        end else begin
          fail_ev = 1'b1;
        end
      end
      PW_ENTRY: if (timeout) begin
        state_n = IDLE;
        id_ok_n = 1'b0;
        buf_n   = '0;
        dcnt_n  = '0;
      end else if (enter) begin
        buf_n = shifted[PW_W-1:0];
        if (digit_cnt != CNT_MAX) dcnt_n = digit_cnt + 1'b1;
        if (digit_cnt == PW_LAST) state_n = CHECK;
      end
      CHECK: begin
        id_ok_n = 1'b0;
        buf_n   = '0;
        if (pw_buf == stored_pw) begin
          state_n = GRANTED;
          li_n    = 1'b1;
          fcnt_n  = '0;
        end else begin
          dcnt_n  = '0;
          fail_ev = 1'b1;
        end
      end
      GRANTED: if (logout || timeout) begin
        state_n = IDLE;
        li_n    = 1'b0;
        dcnt_n  = '0;
      end
      LOCKOUT: if (lock_cnt == '0) begin
        state_n  = IDLE;
        locked_n = 1'b0;
        fcnt_n   = '0;
      end else begin
        lcnt_n = lock_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // Shared failure rule for a bad ID and a bad password.
    if (fail_ev) begin
      if (fail_cnt == FAIL_LAST || fail_cnt == FAIL_MAX) begin
        state_n  = LOCKOUT;
        locked_n = 1'b1;
        fcnt_n   = FAIL_MAX;
        lcnt_n   = LOCK_INIT;
      end else begin
        state_n = IDLE;
        fcnt_n  = fail_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pw_buf     <= '0;
      lock_cnt   <= '0;
      digit_cnt  <= '0;
      fail_cnt   <= '0;
      matched_id <= '0;
      id_ok      <= 1'b0;
      logged_in  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      pw_buf     <= buf_n;
      lock_cnt   <= lcnt_n;
      digit_cnt  <= dcnt_n;
      fail_cnt   <= fcnt_n;
      matched_id <= idx_n;
      id_ok      <= id_ok_n;
      logged_in  <= li_n;
      locked     <= locked_n;
    end
  end

endmodule

// File: tb/tb_multi_user_auth.sv
// Directed bench for multi_user_auth: default table instance plus a 3-digit, 8-user, single-failure instance.
module tb_multi_user_auth;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_in = '0;
  logic       enter = 1'b0, logout = 1'b0, timeout = 1'b0;

  logic       logged_in, id_ok, locked;
  logic [1:0] matched_id, digit_cnt, fail_cnt;

  logic       sw_logged_in, sw_id_ok, sw_locked;
  logic [2:0] sw_matched_id;
  logic [1:0] sw_digit_cnt;
  logic [0:0] sw_fail_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multi_user_auth dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .enter(enter), .logout(logout),
    .timeout(timeout), .logged_in(logged_in), .id_ok(id_ok), .matched_id(matched_id),
    .digit_cnt(digit_cnt), .fail_cnt(fail_cnt), .locked(locked)
  );

  multi_user_auth #(
    .NUM_USERS(8), .DIGIT_W(4), .PW_DIGITS(3),
    .ID_TABLE(32'h87654321),
    .PW_TABLE(96'h888_777_666_555_444_333_222_123),
    .MAX_FAIL(1), .LOCK_CYCLES(4)
  ) dut_sw (
    .clk(clk), .rst(rst), .digit_in(digit_in), .enter(enter), .logout(logout),
    .timeout(timeout), .logged_in(sw_logged_in), .id_ok(sw_id_ok), .matched_id(sw_matched_id),
    .digit_cnt(sw_digit_cnt), .fail_cnt(sw_fail_cnt), .locked(sw_locked)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit_in = d;
    enter    = 1'b1;
    tick();
    enter    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests++; if ({logged_in, id_ok, matched_id, digit_cnt, fail_cnt, locked} !== 9'd0) begin
      fails++; $display("FAIL reset_outputs: got %b expected all zero", {logged_in, id_ok, matched_id, digit_cnt, fail_cnt, locked}); end
    tests++; if ({sw_logged_in, sw_id_ok, sw_matched_id, sw_digit_cnt, sw_fail_cnt, sw_locked} !== 9'd0) begin
      fails++; $display("FAIL reset_outputs_sweep: got %b expected all zero", {sw_logged_in, sw_id_ok, sw_matched_id, sw_digit_cnt, sw_fail_cnt, sw_locked}); end
    rst = 1'b0;
  endtask

  task automatic test_login();
    do_reset();
    press(4'h2);
    tests++; if ({id_ok, matched_id, digit_cnt} !== {1'b1, 2'd1, 2'd0}) begin
      fails++; $display("FAIL login_id: got id_ok=%0b idx=%0d cnt=%0d expected 1 1 0", id_ok, matched_id, digit_cnt); end
    press(4'h3);
    tests++; if (digit_cnt !== 2'd1) begin
      fails++; $display("FAIL login_cnt1: got %0d expected 1", digit_cnt); end
    press(4'hC);
    tests++; if ({digit_cnt, logged_in} !== {2'd2, 1'b0}) begin
      fails++; $display("FAIL login_cnt2: got cnt=%0d li=%0b expected 2 0", digit_cnt, logged_in); end
    tick();
    tests++; if ({logged_in, id_ok, fail_cnt} !== {1'b1, 1'b0, 2'd0}) begin
      fails++; $display("FAIL login_granted: got li=%0b id_ok=%0b fail=%0d expected 1 0 0", logged_in, id_ok, fail_cnt); end
  endtask

  task automatic test_wrong_pw();
    do_reset();
    press(4'h1);
    press(4'hA);
    press(4'h4);
    tick();
    tests++; if ({fail_cnt, logged_in, id_ok, digit_cnt, locked} !== {2'd1, 1'b0, 1'b0, 2'd0, 1'b0}) begin
      fails++; $display("FAIL wrong_pw: got fail=%0d li=%0b id_ok=%0b cnt=%0d lk=%0b expected 1 0 0 0 0",
                        fail_cnt, logged_in, id_ok, digit_cnt, locked); end
  endtask

  task automatic test_lockout();
    int n;
    do_reset();
    press(4'h9);
    tests++; if (fail_cnt !== 2'd1) begin
      fails++; $display("FAIL bad_id_fail1: got %0d expected 1", fail_cnt); end
    press(4'h9);
    tests++; if ({fail_cnt, locked} !== {2'd2, 1'b0}) begin
      fails++; $display("FAIL bad_id_fail2: got fail=%0d lk=%0b expected 2 0", fail_cnt, locked); end
    press(4'h1);
    press(4'hA);
    press(4'h4);
    tick();
    tests++; if ({locked, fail_cnt} !== {1'b1, 2'd3}) begin
      fails++; $display("FAIL lock_enter: got lk=%0b fail=%0d expected 1 3", locked, fail_cnt); end
    n = 1;
    for (int i = 0; i < 40 && locked === 1'b1; i++) begin
      if (i == 2) begin digit_in = 4'h2; enter = 1'b1; end
      if (i == 5) logout = 1'b1;
      tick();
      enter  = 1'b0;
      logout = 1'b0;
      if (locked === 1'b1) n++;
    end
    tests++; if (n != 16) begin
      fails++; $display("FAIL lock_duration: got %0d cycles expected 16", n); end
    tests++; if ({locked, fail_cnt, id_ok} !== {1'b0, 2'd0, 1'b0}) begin
      fails++; $display("FAIL lock_exit: got lk=%0b fail=%0d id_ok=%0b expected 0 0 0", locked, fail_cnt, id_ok); end
  endtask

  task automatic test_timeout();
    do_reset();
    press(4'h9);
    press(4'h3);
    tests++; if ({id_ok, matched_id} !== {1'b1, 2'd2}) begin
      fails++; $display("FAIL to_id: got id_ok=%0b idx=%0d expected 1 2", id_ok, matched_id); end
    press(4'h7);
    tests++; if (digit_cnt !== 2'd1) begin
      fails++; $display("FAIL to_cnt: got %0d expected 1", digit_cnt); end
    digit_in = 4'h5; enter = 1'b1; timeout = 1'b1;
    tick();
    enter = 1'b0; timeout = 1'b0;
    tests++; if ({id_ok, digit_cnt, fail_cnt} !== {1'b0, 2'd0, 2'd1}) begin
      fails++; $display("FAIL to_abort: got id_ok=%0b cnt=%0d fail=%0d expected 0 0 1", id_ok, digit_cnt, fail_cnt); end
    tick();
    tick();
    tests++; if ({fail_cnt, logged_in, locked} !== {2'd1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL to_no_check: got fail=%0d li=%0b lk=%0b expected 1 0 0", fail_cnt, logged_in, locked); end
  endtask

  task automatic test_session();
    do_reset();
    press(4'h4); press(4'h0); press(4'hF);
    tests++; if (logged_in !== 1'b0) begin
      fails++; $display("FAIL sess_latency: got %0b expected 0", logged_in); end
    tick();
    tests++; if ({logged_in, matched_id} !== {1'b1, 2'd3}) begin
      fails++; $display("FAIL sess_login: got li=%0b idx=%0d expected 1 3", logged_in, matched_id); end
    press(4'h2);
    tests++; if ({logged_in, id_ok} !== {1'b1, 1'b0}) begin
      fails++; $display("FAIL sess_enter_ignored: got li=%0b id_ok=%0b expected 1 0", logged_in, id_ok); end
    logout = 1'b1;
    tick();
    logout = 1'b0;
    tests++; if ({logged_in, matched_id, digit_cnt} !== {1'b0, 2'd3, 2'd0}) begin
      fails++; $display("FAIL sess_logout: got li=%0b idx=%0d cnt=%0d expected 0 3 0", logged_in, matched_id, digit_cnt); end
    press(4'h4); press(4'h0); press(4'hF);
    tick();
    tests++; if (logged_in !== 1'b1) begin
      fails++; $display("FAIL sess_relogin: got %0b expected 1", logged_in); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({logged_in, id_ok, matched_id, digit_cnt, fail_cnt, locked} !== 9'd0) begin
      fails++; $display("FAIL sess_async_rst: got %b expected all zero", {logged_in, id_ok, matched_id, digit_cnt, fail_cnt, locked}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    do_reset();
    press(4'h1);
    tests++; if ({sw_id_ok, sw_matched_id} !== {1'b1, 3'd0}) begin
      fails++; $display("FAIL sw_id: got id_ok=%0b idx=%0d expected 1 0", sw_id_ok, sw_matched_id); end
    press(4'h1); press(4'h2);
    tick();
    tests++; if ({sw_digit_cnt, sw_id_ok, sw_logged_in} !== {2'd2, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sw_two_digits: got cnt=%0d id_ok=%0b li=%0b expected 2 1 0", sw_digit_cnt, sw_id_ok, sw_logged_in); end
    press(4'h3);
    tick();
    tests++; if (sw_logged_in !== 1'b1) begin
      fails++; $display("FAIL sw_login: got %0b expected 1", sw_logged_in); end
    logout = 1'b1;
    tick();
    logout = 1'b0;
    press(4'h9);
    tests++; if ({sw_locked, sw_fail_cnt, sw_logged_in} !== {1'b1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sw_single_fail_lock: got lk=%0b fail=%0d li=%0b expected 1 1 0", sw_locked, sw_fail_cnt, sw_logged_in); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_login();
    test_wrong_pw();
    test_lockout();
    test_timeout();
    test_session();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
